regfile_onehot_port: RTL
========================

Name: regfile_onehot_port

Overview:
- 32x32 register file that sits on the receiving end of the write-select interface.
- Consumes the registered one-hot 32-bit write selector produced by the write-address decoder, plus aligned write data.
- Provides two synchronous read ports with write-to-read bypass for the CPU datapath.
- Reports malformed (non-one-hot) selectors.

Parameters:
- DWIDTH, 32, data width of each register and of the read/write data ports.
- ZERO_REG0, 1, when 1 register 0 always reads as zero and ignores writes.

Ports:
- Clock  input  1  single clock; all state updates on rising edge.
- Resetn  input  1  asynchronous active-low reset.
- Selector  input  32  one-hot write select; bit i selects register i; all-zero means no write.
- WriData  input  DWIDTH  write data, valid in the same cycle as Selector.
- RdAddA  input  5  read address, port A.
- RdAddB  input  5  read address, port B.
- RdEn  input  1  read request; captures both addresses this cycle.
- RdDataA  output  DWIDTH  registered read data, port A.
- RdDataB  output  DWIDTH  registered read data, port B.
- RdValid  output  1  high for exactly one cycle when RdDataA/B hold data for a captured request.
- SelErr  output  1  one-cycle pulse: the previous cycle's Selector had more than one bit set.
- SelErrCnt  output  8  saturating count of malformed selectors since reset.

Behaviour:
- Reset (Resetn low, asynchronous, takes effect immediately regardless of Clock):
  - All 32 registers = 0.
  - RdDataA = RdDataB = 0.
  - RdValid = 0, SelErr = 0, SelErrCnt = 0.
  - A request or write pending at reset assertion is dropped; nothing is written.
- Write classification each rising edge, by popcount of Selector:
  - 0: no write.
  - 1: register at the set bit index loads WriData.
  - ≥2: no register is modified; SelErr = 1 next cycle; SelErrCnt increments, saturating at 255.
- With ZERO_REG0 = 1:
  - Selector = 32'h00000001 is a legal, discarded write; SelErr stays 0.
  - Register 0 reads 0 on both ports, including via bypass.
- Read port, fixed 1-cycle latency:
  - RdEn high at edge N gives RdDataA/B and RdValid = 1 after edge N (valid during cycle N+1).
  - RdEn low at edge N gives RdValid = 0 after edge N; RdDataA/B hold their previous values.
  - Back-to-back RdEn gives one result per cycle with no bubbles.
- Bypass (write-first): if a legal one-hot write at edge N targets the same index as RdAddA and/or RdAddB sampled at edge N, that port returns WriData, not the old contents. A rejected multi-hot write never bypasses.
- RdAddA == RdAddB is legal; both ports return the same value.
- Timing: the write-address decoder registers Selector one cycle after WriAdd/WriEn. WriData must be delayed by one cycle upstream so it is aligned with Selector; this block does no realignment.
- No backpressure: reads are always accepted, writes are always applied or rejected in the same edge.
- Combinational paths: none from inputs to outputs; all outputs are registered.

Test Plan:
- Reset/idle: assert Resetn=0 mid-stream → all outputs 0 immediately. Release, then read all 32 registers → every RdData = 0, RdValid pulses once per RdEn.
- Basic write/read: Selector=32'h00000020, WriData=32'hDEADBEEF at edge 1; RdEn with RdAddA=5 at edge 3 → RdDataA=32'hDEADBEEF, RdValid=1 after edge 3, then 0 after edge 4.
- Bypass, same edge: Selector=32'h80000000, WriData=32'h12345678, RdEn, RdAddA=31, RdAddB=31 at one edge → both ports = 32'h12345678 after that edge; register 31 holds that value on a later read.
- Register 0: Selector=32'h00000001, WriData=32'hFFFFFFFF → SelErr stays 0. Read addr 0 at the same edge and later → 0.
- Malformed selector: Selector=32'h00000006, WriData=32'hAAAA5555 → SelErr pulses 1 for one cycle, SelErrCnt=1, registers 1 and 2 unchanged. Apply 300 malformed selectors → SelErrCnt=255.
- Throughput: 32 consecutive cycles of writes (each register i ← i*3) while reading register i-1 each cycle → RdValid high continuously, every read value matches the expected write value.

Source files
------------

// File: rtl/regfile_onehot_port.sv
// regfile_onehot_port: 32-entry register file written by a one-hot selector, two bypassed synchronous read ports
module regfile_onehot_port #(
  parameter int DWIDTH = 32,
  parameter bit ZERO_REG0 = 1'b1
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic [31:0]       Selector,
  input  logic [DWIDTH-1:0] WriData,
  input  logic [4:0]        RdAddA,
  input  logic [4:0]        RdAddB,
  input  logic              RdEn,
  output logic [DWIDTH-1:0] RdDataA,
  output logic [DWIDTH-1:0] RdDataB,
  output logic              RdValid,
  output logic              SelErr,
  output logic [7:0]        SelErrCnt
);
  logic [DWIDTH-1:0] regs [32];
  logic multiHot;
  logic wrEn;
  assign multiHot = |(Selector & (Selector - 32'd1));
  assign wrEn = (|Selector) && !multiHot && !(ZERO_REG0 && Selector[0]);
  // Storage: a legal one-hot selector loads WriData into the selected register
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else begin
      for (int i = 0; i < 32; i++) if (wrEn && Selector[i]) regs[i] <= WriData;
    end
  end
  // Read ports: one-cycle latency, write-first bypass on a same-edge legal write
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      RdDataA <= '0;
      RdDataB <= '0;
      RdValid <= 1'b0;
    end else begin
      RdValid <= RdEn;
      if (RdEn) begin
        RdDataA <= (wrEn && Selector[RdAddA]) ? WriData : regs[RdAddA];
        RdDataB <= (wrEn && Selector[RdAddB]) ? WriData : regs[RdAddB];
      end
    end
  end
  // Malformed selector reporting: one-cycle pulse and saturating counter
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      SelErr <= 1'b0;
      SelErrCnt <= '0;
    end else begin
      SelErr <= multiHot;
      SelErrCnt <= (multiHot && SelErrCnt != 8'hFF) ? SelErrCnt + 8'd1 : SelErrCnt;
    end
  end
endmodule
